// File: rtl/p_cacheline_adaptor_if.sv
// Line-request (pmem_*) and burst-memory (mem_*) signal bundle for p_cacheline_adaptor.
// slave = adaptor view, master = requester + main-memory view.
interface p_cacheline_adaptor_if #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64
);
   logic [31:0]        pmem_address;
   logic               pmem_read;
   logic               pmem_write;
   logic [LINE_W-1:0]  pmem_wdata;
   logic [LINE_W-1:0]  pmem_rdata;
   logic               pmem_resp;

   logic [31:0]        mem_address;
   logic               mem_read;
   logic               mem_write;
   logic [BURST_W-1:0] mem_wdata;
   logic [BURST_W-1:0] mem_rdata;
   logic               mem_resp;

   modport slave (
      input  pmem_address, pmem_read, pmem_write, pmem_wdata, mem_rdata, mem_resp,
      output pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
   );

   modport master (
      output pmem_address, pmem_read, pmem_write, pmem_wdata, mem_rdata, mem_resp,
      input  pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_wdata
   );
endinterface

// File: rtl/p_cacheline_adaptor.sv
// Converts cache line fills/writebacks into BEATS-beat bursts on main memory.
// Option ADAPTOR_EARLY_RESP_EN: read response asserted combinationally on the final beat.
module p_cacheline_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64
) (
   input logic                   clk,
   input logic                   rst,
   p_cacheline_adaptor_if.slave  bus
);
   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [31:0] ADDR_MASK = ~32'((LINE_W / 8) - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       addr;
   // Separate fill and writeback buffers so pmem_rdata survives an intervening writeback.
   logic [LINE_W-1:0] rd_buf;
   logic [LINE_W-1:0] wr_buf;
   logic              beat_last;

   assign beat_last = bus.mem_resp && (cnt == LAST_BEAT);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.pmem_write)     state_next = WRITE;
            else if (bus.pmem_read) state_next = READ;
         end
         READ: begin
`ifdef ADAPTOR_EARLY_RESP_EN
            if (beat_last) state_next = IDLE;
`else
            if (beat_last) state_next = DONE;
`endif
         end
         WRITE: begin
            if (beat_last) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         addr   <= '0;
         rd_buf <= '0;
         wr_buf <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (bus.pmem_write || bus.pmem_read) addr <= bus.pmem_address & ADDR_MASK;
               if (bus.pmem_write) wr_buf <= bus.pmem_wdata;
            end
            READ: begin
               if (bus.mem_resp) begin
                  rd_buf[BURST_W*cnt +: BURST_W] <= bus.mem_rdata;
                  cnt <= cnt + 1'b1;
               end
            end
            WRITE: begin
               if (bus.mem_resp) cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_read    = (state == READ);
   assign bus.mem_write   = (state == WRITE);
   assign bus.mem_address = addr;
   assign bus.mem_wdata   = wr_buf[BURST_W*cnt +: BURST_W];

`ifdef ADAPTOR_EARLY_RESP_EN
   logic early_hit;
   assign early_hit      = (state == READ) && beat_last;
   assign bus.pmem_resp  = (state == DONE) || early_hit;
   assign bus.pmem_rdata = early_hit ? {bus.mem_rdata, rd_buf[LINE_W-BURST_W-1:0]} : rd_buf;
`else
   assign bus.pmem_resp  = (state == DONE);
   assign bus.pmem_rdata = rd_buf;
`endif
endmodule

// File: tb/tb_p_cacheline_adaptor.sv
// Self-checking bench for p_cacheline_adaptor: vector table, response scoreboard,
// hand sequences for read-data hold and mid-burst reset.
module tb_p_cacheline_adaptor;
   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int BEATS   = LINE_W / BURST_W;
`ifdef ADAPTOR_EARLY_RESP_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   p_cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W)) bus ();

   p_cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      bit                is_read;
      logic [LINE_W-1:0] line;
   } sb_t;

   // op: 0 = read, 1 = write, 2 = read and write together
   typedef struct {
      int                op;
      logic [31:0]       addr;
      logic [LINE_W-1:0] line;
      int                gap;
      logic [31:0]       exp_addr;
   } vec_t;

   sb_t  sb[$];
   sb_t  mon_e;
   sb_t  dropped;
   vec_t vecs[5];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [LINE_W-1:0] act,
                      input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Response scoreboard: every pmem_resp pops one expected transaction.
   always @(negedge clk) begin
      if (!rst) begin
         chk("no_overlap", {255'd0, bus.mem_read & bus.mem_write}, '0);
         if (bus.pmem_resp) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL sb_unexpected_resp: got pmem_resp=1 required no response");
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.is_read) chk("sb_rdata", bus.pmem_rdata, mon_e.line);
            end
         end
      end
   end

   task automatic beat_chk(input bit w, input logic [31:0] exp_addr,
                           input logic [LINE_W-1:0] line, input int b, input bit exp_resp);
      chk("mem_address", bus.mem_address, exp_addr);
      chk(w ? "mem_write_level" : "mem_read_level", {bus.mem_read, bus.mem_write},
          w ? 2'b01 : 2'b10);
      chk("beat_resp", bus.pmem_resp, exp_resp);
      if (w) chk("mem_wdata", bus.mem_wdata, line[b*BURST_W +: BURST_W]);
   endtask

   // Entered at #1 after the edge into the burst state; leaves at #1 after the edge into IDLE.
   task automatic do_burst(input bit w, input logic [31:0] exp_addr,
                           input logic [LINE_W-1:0] line, input int gap);
      for (int b = 0; b < BEATS; b++) begin
         for (int g = 0; g < gap; g++) begin
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            @(negedge clk);
            beat_chk(w, exp_addr, line, b, 1'b0);
            @(posedge clk); #1;
         end
         bus.mem_resp  = 1'b1;
         bus.mem_rdata = w ? 64'hDEAD_BEEF_0BAD_F00D : line[b*BURST_W +: BURST_W];
         @(negedge clk);
         beat_chk(w, exp_addr, line, b, EARLY && !w && (b == BEATS - 1));
         if (EARLY && !w && (b == BEATS - 1)) bus.pmem_read = 1'b0;
         @(posedge clk); #1;
      end
      bus.mem_resp = 1'b0;
      if (!(EARLY && !w)) begin
         @(negedge clk);
         chk("done_resp", bus.pmem_resp, 1'b1);
         chk("done_bus_idle", {bus.mem_read, bus.mem_write}, 2'b00);
         if (w) bus.pmem_write = 1'b0;
         else   bus.pmem_read  = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic run_vec(input vec_t v);
      bus.pmem_address = v.addr;
      bus.pmem_wdata   = v.line;
      bus.pmem_write   = (v.op != 0);
      bus.pmem_read    = (v.op != 1);
      if (v.op != 0) sb.push_back('{1'b0, v.line});
      if (v.op != 1) sb.push_back('{1'b1, v.line});
      @(posedge clk); #1;
      // Changes during the burst must be ignored.
      bus.pmem_address = ~v.addr;
      bus.pmem_wdata   = ~v.line;
      if (v.op == 0) begin
         do_burst(1'b0, v.exp_addr, v.line, v.gap);
      end else begin
         do_burst(1'b1, v.exp_addr, v.line, v.gap);
         if (v.op == 2) begin
            bus.pmem_address = v.addr;
            @(negedge clk);
            chk("dual_idle_gap", {bus.mem_read, bus.mem_write, bus.pmem_resp}, 3'b000);
            @(posedge clk); #1;
            do_burst(1'b0, v.exp_addr, v.line, v.gap);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{0, 32'h0000_1234,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 32'h0000_1220};
      vecs[1] = '{1, 32'h8000_0040,
                  {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 0, 32'h8000_0040};
      vecs[2] = '{0, 32'h0000_ABFF,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}, 2, 32'h0000_ABE0};
      vecs[3] = '{2, 32'h4000_007C,
                  {64'h1357_9BDF_2468_ACE0, 64'h5555_AAAA_5555_AAAA,
                   64'h0000_0000_FFFF_FFFF, 64'h8765_4321_0FED_CBA9}, 1, 32'h4000_0060};
      vecs[4] = '{1, 32'hFFFF_FFFF,
                  {64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                   64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738}, 1, 32'hFFFF_FFE0};

      bus.pmem_address = '0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_wdata   = '0;
      bus.mem_rdata    = '0;
      bus.mem_resp     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("reset_ctrl", {bus.pmem_resp, bus.mem_read, bus.mem_write}, 3'b000);
      chk("reset_mem_address", bus.mem_address, '0);
      chk("reset_mem_wdata", bus.mem_wdata, '0);
      chk("reset_pmem_rdata", bus.pmem_rdata, '0);
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Fill data must survive a following writeback.
      run_vec(vecs[2]);
      run_vec(vecs[1]);
      @(negedge clk);
      chk("rdata_hold", bus.pmem_rdata, vecs[2].line);
      @(posedge clk); #1;

      // Reset after two beats of a read.
      bus.pmem_address = 32'h0000_2040;
      bus.pmem_read    = 1'b1;
      @(posedge clk); #1;
      for (int b = 0; b < 2; b++) begin
         bus.mem_resp  = 1'b1;
         bus.mem_rdata = 64'h7777_0000_7777_0000 + 64'(b);
         @(posedge clk); #1;
      end
      rst              = 1'b1;
      bus.mem_resp     = 1'b0;
      bus.pmem_read    = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_abort_ctrl", {bus.pmem_resp, bus.mem_read, bus.mem_write}, 3'b000);
      chk("rst_abort_address", bus.mem_address, '0);
      chk("rst_abort_rdata", bus.pmem_rdata, '0);
      // Stray beats after the abort are ignored.
      for (int s = 0; s < 2; s++) begin
         @(posedge clk); #1;
         bus.mem_resp  = 1'b1;
         bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
         @(negedge clk);
         chk("stray_resp_ignored", {bus.pmem_resp, bus.mem_read, bus.mem_write}, 3'b000);
      end
      @(posedge clk); #1;
      bus.mem_resp = 1'b0;
      run_vec(vecs[0]);

      repeat (2) @(posedge clk);
      chk("sb_drained", 256'(sb.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
